// File: rtl/exec_sequencer_pkg.sv
// Shared state encoding and constants for the multi-cycle instruction sequencer.
package exec_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WRITE  = 3'd5,
        S_HALT   = 3'd6
    } seq_state_t;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/exec_sequencer_if.sv
// Bundle of memory handshakes, stage strobes and decoded fields around the sequencer.
interface exec_sequencer_if;

    logic        imem_req;
    logic        imem_ready;
    logic [31:0] instr_in;
    logic [31:0] instr_reg;
    logic [31:0] pc;
    logic        dec_en;
    logic        ex_en;
    logic        is_mem;
    logic        is_branch;
    logic [31:0] alu_result;
    logic [31:0] imm;
    logic        mem_req;
    logic        mem_done;
    logic        wb_en;
    logic        halt_req;
    logic        halted;
    logic [31:0] retired;

    modport master (
        output imem_req, instr_reg, pc, dec_en, ex_en, mem_req, wb_en, halted, retired,
        input  imem_ready, instr_in, is_mem, is_branch, alu_result, imm, mem_done, halt_req
    );

    modport slave (
        input  imem_req, instr_reg, pc, dec_en, ex_en, mem_req, wb_en, halted, retired,
        output imem_ready, instr_in, is_mem, is_branch, alu_result, imm, mem_done, halt_req
    );

endinterface

// File: rtl/exec_sequencer_pc_next.sv
// Next-PC adder: branch target when taken, sequential step otherwise; wraps modulo 2^32.
module exec_sequencer_pc_next
    import exec_sequencer_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] imm_q,
    input  logic        take,
    output logic [31:0] pc_next
);

    assign pc_next = pc + (take ? imm_q : PC_STEP);

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle control FSM: fetch, decode, execute, optional memory access, writeback.
module exec_sequencer
    import exec_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
    input  logic                 clk,
    input  logic                 rstn,
    exec_sequencer_if.master     bus
);

    seq_state_t  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_reg_q, instr_reg_d;
    logic [31:0] retired_q, retired_d;
    logic [31:0] imm_q, imm_d;
    logic        take_q, take_d;
    logic        halt_pend_q, halt_pend_d;
    logic        halt_seen;
    logic [31:0] pc_next;
    logic        alu_hi_unused;

    // Only bit 0 of the ALU result carries the branch condition.
    assign alu_hi_unused = ^bus.alu_result[31:1];

    exec_sequencer_pc_next u_pc_next (
        .pc      (pc_q),
        .imm_q   (imm_q),
        .take    (take_q),
        .pc_next (pc_next)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_reg_d = instr_reg_q;
        retired_d   = retired_q;
        imm_d       = imm_q;
        take_d      = take_q;
        halt_seen   = halt_pend_q | bus.halt_req;
        halt_pend_d = (state_q == S_HALT) ? halt_pend_q : halt_seen;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (bus.imem_ready) begin
                    state_d     = S_DECODE;
                    instr_reg_d = bus.instr_in;
                end
            end
            S_DECODE: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                take_d  = bus.is_branch & bus.alu_result[0];
                imm_d   = bus.imm;
                state_d = bus.is_mem ? S_MEM : S_WRITE;
            end
            S_MEM: begin
                if (bus.mem_done) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                // A halt request arriving in this very cycle still stops after this instruction.
                pc_d      = pc_next;
                retired_d = retired_q + 32'd1;
                state_d   = halt_seen ? S_HALT : S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            instr_reg_q <= 32'd0;
            retired_q   <= 32'd0;
            imm_q       <= 32'd0;
            take_q      <= 1'b0;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_reg_q <= instr_reg_d;
            retired_q   <= retired_d;
            imm_q       <= imm_d;
            take_q      <= take_d;
            halt_pend_q <= halt_pend_d;
        end
    end

    // Strobes decode straight from the state flop, so an async reset drops them at once.
    assign bus.imem_req  = (state_q == S_FETCH);
    assign bus.dec_en    = (state_q == S_DECODE);
    assign bus.ex_en     = (state_q == S_EXEC);
    assign bus.mem_req   = (state_q == S_MEM);
    assign bus.wb_en     = (state_q == S_WRITE);
    assign bus.halted    = (state_q == S_HALT);
    assign bus.pc        = pc_q;
    assign bus.instr_reg = instr_reg_q;
    assign bus.retired   = retired_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: reset, sequential stream, branches, memory wait, reset abort, wraps, halt.
module tb_exec_sequencer;
    import exec_sequencer_pkg::*;

    logic clk;
    logic rstn;
    int   compared   = 0;
    int   mismatched = 0;
    int   mem_req_cycles;
    int   wb_cycles;

    exec_sequencer_if bus ();

    exec_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkFlag(input string tag, input logic observed, input logic expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    task automatic checkState(input string tag, input seq_state_t expected);
        checkOutput(tag, {29'd0, dut.state_q}, {29'd0, expected});
    endtask

    task automatic applyStimulus(input logic mem, input logic branch, input logic [31:0] alu, input logic [31:0] imm_v);
        bus.is_mem     = mem;
        bus.is_branch  = branch;
        bus.alu_result = alu;
        bus.imm        = imm_v;
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rstn         = 1'b0;
        bus.imem_ready = 1'b1;
        bus.instr_in = 32'h0000_0013;
        bus.mem_done = 1'b0;
        bus.halt_req = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        $display("[TB] start");

        tick(2);
        checkFlag("rst_imem_req", bus.imem_req, 1'b0);
        checkOutput("rst_pc", bus.pc, 32'h0);
        checkOutput("rst_retired", bus.retired, 32'h0);
        checkOutput("rst_instr_reg", bus.instr_reg, 32'h0);
        checkFlag("rst_halted", bus.halted, 1'b0);
        checkState("rst_state", S_IDLE);

        // Sequential non-memory stream with zero-wait fetch
        rstn = 1'b1;
        checkFlag("cyc1_imem_req", bus.imem_req, 1'b0);
        tick();
        checkFlag("cyc2_imem_req", bus.imem_req, 1'b1);
        checkOutput("i0_pc", bus.pc, 32'h0);
        tick();
        checkFlag("i0_dec_en", bus.dec_en, 1'b1);
        checkOutput("i0_instr_reg", bus.instr_reg, 32'h0000_0013);
        tick();
        checkFlag("i0_ex_en", bus.ex_en, 1'b1);
        tick();
        checkFlag("i0_wb_en", bus.wb_en, 1'b1);
        checkOutput("i0_pc_before_wb", bus.pc, 32'h0);
        tick();
        checkFlag("i1_imem_req", bus.imem_req, 1'b1);
        checkOutput("i1_pc", bus.pc, 32'h4);
        checkOutput("i1_retired", bus.retired, 32'd1);
        bus.instr_in = 32'h00A0_0093;
        tick();
        checkOutput("i1_instr_reg", bus.instr_reg, 32'h00A0_0093);
        tick(3);
        checkFlag("i2_imem_req", bus.imem_req, 1'b1);
        checkOutput("i2_pc", bus.pc, 32'h8);
        checkOutput("i2_retired", bus.retired, 32'd2);
        tick(8);
        checkOutput("i4_pc", bus.pc, 32'h10);
        checkOutput("i4_retired", bus.retired, 32'd4);

        // Taken backward branch at pc 0x10
        tick(2);
        applyStimulus(1'b0, 1'b1, 32'd1, 32'hFFFF_FFF8);
        tick();
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        checkOutput("br_taken_pc_in_wb", bus.pc, 32'h10);
        tick();
        checkOutput("br_taken_pc", bus.pc, 32'h8);
        checkOutput("br_taken_retired", bus.retired, 32'd5);

        // Not-taken branch at pc 0x10
        tick(8);
        checkOutput("br_nt_start_pc", bus.pc, 32'h10);
        tick(2);
        applyStimulus(1'b0, 1'b1, 32'd0, 32'hFFFF_FFF8);
        tick();
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        checkOutput("br_nt_pc", bus.pc, 32'h14);
        checkOutput("br_nt_retired", bus.retired, 32'd8);

        // Load with mem_done arriving in the fourth MEM cycle
        mem_req_cycles = 0;
        wb_cycles      = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i <= 7) begin
                mem_req_cycles += int'(bus.mem_req);
                wb_cycles      += int'(bus.wb_en);
            end
            case (i)
                2: applyStimulus(1'b1, 1'b0, 32'd0, 32'd0);
                3: applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
                6: bus.mem_done = 1'b1;
                7: bus.mem_done = 1'b0;
                default: ;
            endcase
        end
        checkOutput("load_mem_req_cycles", mem_req_cycles, 32'd4);
        checkOutput("load_wb_cycles", wb_cycles, 32'd1);
        checkFlag("load_refetch_at_8", bus.imem_req, 1'b1);
        checkOutput("load_pc", bus.pc, 32'h18);
        checkOutput("load_retired", bus.retired, 32'd9);

        // Async reset while a data request is outstanding, with a halt pending
        tick();
        bus.halt_req = 1'b1;
        tick();
        bus.halt_req = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'd0, 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        checkFlag("abort_mem_req_before", bus.mem_req, 1'b1);
        #2 rstn = 1'b0;
        #1;
        checkFlag("abort_mem_req_async", bus.mem_req, 1'b0);
        checkOutput("abort_pc", bus.pc, 32'h0);
        checkOutput("abort_retired", bus.retired, 32'd0);
        checkState("abort_state", S_IDLE);
        tick();
        rstn = 1'b1;
        tick();
        checkFlag("abort_refetch", bus.imem_req, 1'b1);

        // PC and retired-count wraparound
        force dut.pc_q = 32'hFFFF_FFFC;
        force dut.retired_q = 32'hFFFF_FFFF;
        tick();
        release dut.pc_q;
        release dut.retired_q;
        checkOutput("wrap_pc_preload", bus.pc, 32'hFFFF_FFFC);
        checkOutput("wrap_retired_preload", bus.retired, 32'hFFFF_FFFF);
        tick(2);
        checkFlag("wrap_wb_en", bus.wb_en, 1'b1);
        tick();
        checkOutput("wrap_pc", bus.pc, 32'h0);
        checkOutput("wrap_retired", bus.retired, 32'd0);
        checkFlag("wrap_no_stale_halt", bus.imem_req, 1'b1);
        checkFlag("wrap_halted", bus.halted, 1'b0);

        // Halt requested in the WRITE cycle itself
        tick(3);
        bus.halt_req = 1'b1;
        tick();
        bus.halt_req = 1'b0;
        checkFlag("halt_wr_halted", bus.halted, 1'b1);
        checkState("halt_wr_state", S_HALT);
        checkOutput("halt_wr_retired", bus.retired, 32'd1);
        checkOutput("halt_wr_pc", bus.pc, 32'h4);

        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        checkFlag("rerst_halted", bus.halted, 1'b0);
        checkFlag("rerst_imem_req", bus.imem_req, 1'b1);

        // One-cycle halt pulse during DECODE
        tick();
        bus.halt_req = 1'b1;
        tick();
        bus.halt_req = 1'b0;
        tick();
        checkFlag("halt_dec_wb_en", bus.wb_en, 1'b1);
        checkFlag("halt_dec_not_yet", bus.halted, 1'b0);
        tick();
        checkFlag("halt_dec_halted", bus.halted, 1'b1);
        checkOutput("halt_dec_retired", bus.retired, 32'd1);
        checkOutput("halt_dec_pc", bus.pc, 32'h4);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkFlag("halt_hold_halted", bus.halted, 1'b1);
            checkFlag("halt_hold_imem_req", bus.imem_req, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
